// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : pc_fetch_unit_pkg
// Brief  : Shared constants for the IF stage: bus widths, boot PC, FSM codes.
// Rev    : 1.0
// ============================================================================
package pc_fetch_unit_pkg;

    localparam int          C_BR2IF_WD  = 65;
    localparam logic [63:0] C_RESET_PC  = 64'h0000_0000_8000_0000;
    localparam int          C_STALL_IF  = 0;

    localparam logic [1:0]  S_RST  = 2'd0;
    localparam logic [1:0]  S_BOOT = 2'd1;
    localparam logic [1:0]  S_RUN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_br_pend.sv
`default_nettype none
// ============================================================================
// Module : if_br_pend
// Brief  : Holds a redirect that arrives while IF is stalled; youngest wins.
// Rev    : 1.0
// ============================================================================
module if_br_pend (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        br_e,
    input  logic [63:0] br_addr,
    output logic        br_pend,
    output logic [63:0] br_pend_addr
);

    logic        r_pend;
    logic [63:0] r_pend_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_addr <= 64'd0;
        end else if (stall_if) begin
            if (br_e) begin
                r_pend      <= 1'b1;
                r_pend_addr <= br_addr;
            end
        end else begin
            // Consumed (or superseded by a same-cycle br_e) on the first unstalled cycle
            r_pend <= 1'b0;
        end
    end

    assign br_pend      = r_pend;
    assign br_pend_addr = r_pend_addr;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : pc_fetch_unit
// Brief  : IF stage: fetch PC, instruction SRAM read port, branch redirects.
// Rev    : 1.0
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = C_RESET_PC,
    parameter int          BR2IF_WD = C_BR2IF_WD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic [BR2IF_WD-1:0] br_bus,
    output logic                pc_valid,
    output logic [63:0]         pc,
    output logic                inst_sram_en,
    output logic [7:0]          inst_sram_we,
    output logic [63:0]         inst_sram_addr,
    output logic [63:0]         inst_sram_wdata
);

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic        r_pc_valid;

    logic        w_stall_if;
    logic        w_br_e;
    logic [63:0] w_br_addr;
    logic        w_br_pend;
    logic [63:0] w_br_pend_addr;
    logic [63:0] w_next_pc;
    logic        w_fetch;
    logic        w_unused_stall;

    assign w_stall_if     = stall[C_STALL_IF];
    assign w_br_e         = br_bus[BR2IF_WD-1];
    assign w_br_addr      = br_bus[63:0];
    assign w_unused_stall = ^stall[5:1];

    if_br_pend u_br_pend (
        .clk          (clk),
        .rst          (rst),
        .stall_if     (w_stall_if),
        .br_e         (w_br_e),
        .br_addr      (w_br_addr),
        .br_pend      (w_br_pend),
        .br_pend_addr (w_br_pend_addr)
    );

    always_comb begin
        w_next_pc = r_pc + 64'd4;
        if (w_br_e) begin
            w_next_pc = w_br_addr;
        end else if (w_br_pend) begin
            w_next_pc = w_br_pend_addr;
        end
    end

    // S_RST spends one idle cycle after release so S_BOOT can fetch RESET_PC itself
    assign w_fetch = !rst && (r_state != S_RST) && !w_stall_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RST;
            r_pc       <= RESET_PC - 64'd4;
            r_pc_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RST: begin
                    r_state <= S_BOOT;
                end
                S_BOOT: begin
                    if (w_fetch) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
            if (w_fetch) begin
                r_pc       <= w_next_pc;
                r_pc_valid <= (r_state != S_RST);
            end
        end
    end

    assign pc              = r_pc;
    assign pc_valid        = r_pc_valid;
    assign inst_sram_en    = w_fetch;
    assign inst_sram_we    = 8'd0;
    assign inst_sram_addr  = w_next_pc;
    assign inst_sram_wdata = 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_fetch_unit
// Brief  : Directed scoreboard bench for the IF-stage fetch unit.
// Rev    : 1.0
// ============================================================================
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
    } exp_t;

    localparam int K_IDLE  = 0;
    localparam int K_FETCH = 1;
    localparam int K_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic [64:0] br_bus = 65'd0;
    logic        pc_valid;
    logic [63:0] pc;
    logic        inst_sram_en;
    logic [7:0]  inst_sram_we;
    logic [63:0] inst_sram_addr;
    logic [63:0] inst_sram_wdata;

    int   checks = 0;
    int   failures = 0;
    int   n_fetch = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .pc_valid        (pc_valid),
        .pc              (pc),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    // Monitor: every presented fetch is matched against the next expected one
    always @(negedge clk) begin
        if (inst_sram_en) begin
            exp_t e;
            checks = checks + 1;
            if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_fetch addr=%h pc=%h valid=%b", inst_sram_addr, pc, pc_valid);
            end else begin
                e = sb.pop_front();
                if (inst_sram_addr !== e.addr || pc !== e.pc || pc_valid !== e.valid
                    || inst_sram_we !== 8'd0 || inst_sram_wdata !== 64'd0) begin
                    failures = failures + 1;
                    $display("FAIL fetch[%0d] addr=%h exp=%h pc=%h exp=%h valid=%b exp=%b we=%h wdata=%h",
                             n_fetch, inst_sram_addr, e.addr, pc, e.pc, pc_valid, e.valid,
                             inst_sram_we, inst_sram_wdata);
                end
            end
            n_fetch = n_fetch + 1;
        end
    end

    task automatic cyc(input string name, input logic r, input logic st, input logic be,
                       input logic [63:0] ba, input int kind, input logic [63:0] e_addr,
                       input logic e_valid, input logic [63:0] e_pc);
        exp_t e;
        @(posedge clk);
        #1;
        rst    = r;
        stall  = {5'd0, st};
        br_bus = {be, ba};
        if (kind == K_FETCH) begin
            e.addr  = e_addr;
            e.valid = e_valid;
            e.pc    = e_pc;
            sb.push_back(e);
        end
        @(negedge clk);
        if (kind == K_HOLD) begin
            checks = checks + 1;
            if (inst_sram_en !== 1'b0 || pc !== e_pc || pc_valid !== e_valid) begin
                failures = failures + 1;
                $display("FAIL %s en=%b exp=0 pc=%h exp=%h valid=%b exp=%b",
                         name, inst_sram_en, pc, e_pc, pc_valid, e_valid);
            end
        end
    endtask

    initial begin
        // Reset state
        cyc("reset0", 1, 0, 0, 64'd0, K_HOLD, 64'd0, 0, 64'h7FFF_FFFC);
        cyc("reset1", 1, 0, 0, 64'd0, K_HOLD, 64'd0, 0, 64'h7FFF_FFFC);
        // Boot sequence
        cyc("post_rst", 0, 0, 0, 64'd0, K_HOLD, 64'd0, 0, 64'h7FFF_FFFC);
        cyc("boot",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_0000, 0, 64'h7FFF_FFFC);
        cyc("seq1",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_0004, 1, 64'h8000_0000);
        cyc("seq2",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_0008, 1, 64'h8000_0004);
        cyc("seq3",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_000C, 1, 64'h8000_0008);
        cyc("seq4",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_0010, 1, 64'h8000_000C);
        // Plain stall
        for (int i = 0; i < 3; i++)
            cyc("stall_hold", 0, 1, 0, 64'd0, K_HOLD, 64'd0, 1, 64'h8000_0010);
        cyc("stall_rel", 0, 0, 0, 64'd0, K_FETCH, 64'h8000_0014, 1, 64'h8000_0010);
        // Unstalled redirect
        cyc("br_now",   0, 0, 1, 64'h8000_0100, K_FETCH, 64'h8000_0100, 1, 64'h8000_0014);
        cyc("br_next",  0, 0, 0, 64'd0,         K_FETCH, 64'h8000_0104, 1, 64'h8000_0100);
        // Two redirects in one stall: youngest wins
        cyc("pend_a",   0, 1, 1, 64'h8000_0200, K_HOLD, 64'd0, 1, 64'h8000_0104);
        cyc("pend_gap", 0, 1, 0, 64'd0,         K_HOLD, 64'd0, 1, 64'h8000_0104);
        cyc("pend_b",   0, 1, 1, 64'h8000_0300, K_HOLD, 64'd0, 1, 64'h8000_0104);
        cyc("pend_rel", 0, 0, 0, 64'd0, K_FETCH, 64'h8000_0300, 1, 64'h8000_0104);
        cyc("pend_clr", 0, 0, 0, 64'd0, K_FETCH, 64'h8000_0304, 1, 64'h8000_0300);
        // Same-cycle br_e beats pending redirect on release
        cyc("pend_c",   0, 1, 1, 64'h8000_0200, K_HOLD, 64'd0, 1, 64'h8000_0304);
        cyc("pend_c2",  0, 1, 0, 64'd0,         K_HOLD, 64'd0, 1, 64'h8000_0304);
        cyc("rel_br",   0, 0, 1, 64'h8000_0400, K_FETCH, 64'h8000_0400, 1, 64'h8000_0304);
        cyc("rel_br1",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_0404, 1, 64'h8000_0400);
        cyc("rel_br2",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_0408, 1, 64'h8000_0404);
        // 64-bit wrap and unaligned target
        cyc("wrap_br",  0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, K_FETCH, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h8000_0408);
        cyc("wrap",     0, 0, 0, 64'd0, K_FETCH, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc("unal_br",  0, 0, 1, 64'h8000_0101, K_FETCH, 64'h8000_0101, 1, 64'h0);
        cyc("unal",     0, 0, 0, 64'd0, K_FETCH, 64'h8000_0105, 1, 64'h8000_0101);
        // Reset discards a pending redirect
        cyc("pend_rst", 0, 1, 1, 64'h8000_0500, K_HOLD, 64'd0, 1, 64'h8000_0105);
        cyc("rst_mid",  1, 0, 0, 64'd0, K_HOLD, 64'd0, 1, 64'h8000_0105);
        cyc("rst_post", 0, 0, 0, 64'd0, K_HOLD, 64'd0, 0, 64'h7FFF_FFFC);
        cyc("reboot",   0, 0, 0, 64'd0, K_FETCH, 64'h8000_0000, 0, 64'h7FFF_FFFC);
        cyc("reboot1",  0, 0, 0, 64'd0, K_FETCH, 64'h8000_0004, 1, 64'h8000_0000);
        cyc("end_rst0", 1, 0, 0, 64'd0, K_HOLD, 64'd0, 1, 64'h8000_0004);
        cyc("end_rst1", 1, 0, 0, 64'd0, K_HOLD, 64'd0, 0, 64'h7FFF_FFFC);

        checks = checks + 1;
        if (sb.size() != 0) begin
            failures = failures + 1;
            $display("FAIL missing_fetches outstanding=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
